cpu_bus1_master: RTL and testbench

- CPU-side master for bus 1, which is the processor-to-cache link carrying C1, A1 and D1.
- Accepts one request at a time from a simple valid/ready interface and serialises it onto bus 1. The address goes in two halves; write data goes in 16-bit halves.
- After sending, it releases C1/D1, waits for the cache to answer C1_RESPONSE, and collects read data.
- Sits directly upstream of Cache, replacing hand-driven testbench stimulus of C1/A1.

---
 rtl/cpu_bus1_master_if.sv | 25 ++
 rtl/cpu_bus1_master.sv | 179 +++++++++++++++++
 tb/tb_cpu_bus1_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus1_master_if.sv
// Request/response handshake between a CPU-side requester and cpu_bus1_master.
interface cpu_bus1_master_if #(
    parameter int unsigned CMD_W  = 3,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [CMD_W-1:0]      req_cmd;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*DATA_W-1:0]   req_wdata;
    logic                  rsp_valid;
    logic [2*DATA_W-1:0]   rsp_rdata;
    logic                  rsp_error;

    modport master (
        input  req_valid, req_cmd, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        output req_valid, req_cmd, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/cpu_bus1_master.sv
// CPU-side master for bus 1: serialises one request onto C1/A1/D1 and collects the cache response.
// Optional response timeout enabled by defining BUS1_TIMEOUT_EN.
module cpu_bus1_master #(
    parameter int unsigned CACHE_TAG_SIZE    = 10,
    parameter int unsigned CACHE_SET_SIZE    = 5,
    parameter int unsigned CACHE_OFFSET_SIZE = 4,
    parameter int unsigned ADDR1_BUS_SIZE    = 15,
    parameter int unsigned DATA1_BUS_SIZE    = 16,
    parameter int unsigned CTR1_BUS_SIZE     = 3,
    parameter int unsigned TIMEOUT_CYCLES    = 255
) (
    input  logic                      CLK,
    input  logic                      RESET,
    cpu_bus1_master_if.master         bus,
    output wire [ADDR1_BUS_SIZE-1:0]  A1,
    inout  wire [DATA1_BUS_SIZE-1:0]  D1,
    inout  wire [CTR1_BUS_SIZE-1:0]   C1
);
    localparam int unsigned ADDR_W  = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE;
    localparam int unsigned RDATA_W = 2 * DATA1_BUS_SIZE;

    localparam logic [CTR1_BUS_SIZE-1:0] CMD_NOP      = CTR1_BUS_SIZE'(0);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ8    = CTR1_BUS_SIZE'(1);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ16   = CTR1_BUS_SIZE'(2);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ32   = CTR1_BUS_SIZE'(3);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE8   = CTR1_BUS_SIZE'(5);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE16  = CTR1_BUS_SIZE'(6);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE32  = CTR1_BUS_SIZE'(7);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_RESPONSE = CTR1_BUS_SIZE'(7);

    // Elaboration-time sanity check on the bus geometry.
    if (ADDR1_BUS_SIZE < CACHE_TAG_SIZE + CACHE_SET_SIZE || ADDR1_BUS_SIZE < CACHE_OFFSET_SIZE ||
        DATA1_BUS_SIZE < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("cpu_bus1_master: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_TURN, S_WAIT, S_RECV2, S_DONE
    } state_t;

    function automatic logic is_read(input logic [CTR1_BUS_SIZE-1:0] c);
        return (c == CMD_READ8) || (c == CMD_READ16) || (c == CMD_READ32);
    endfunction

    function automatic logic is_write(input logic [CTR1_BUS_SIZE-1:0] c);
        return (c == CMD_WRITE8) || (c == CMD_WRITE16) || (c == CMD_WRITE32);
    endfunction

    state_t                        state;
    logic                          req_ready_q;
    logic                          rsp_valid_q;
    logic [RDATA_W-1:0]            rsp_rdata_q;
    logic [CTR1_BUS_SIZE-1:0]      cmd_q;
    logic [CACHE_OFFSET_SIZE-1:0]  offset_q;
    logic [DATA1_BUS_SIZE-1:0]     wdata_hi_q;
    logic                          c1_oe, a1_oe, d1_oe;
    logic [CTR1_BUS_SIZE-1:0]      c1_q;
    logic [ADDR1_BUS_SIZE-1:0]     a1_q;
    logic [DATA1_BUS_SIZE-1:0]     d1_q;

`ifdef BUS1_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] wait_cnt;
    logic             rsp_error_q;
`endif

    // Bus drive values are registered; the enables hand ownership to the cache in TURN.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            cmd_q       <= '0;
            offset_q    <= '0;
            wdata_hi_q  <= '0;
            c1_oe       <= 1'b1;
            c1_q        <= CMD_NOP;
            a1_oe       <= 1'b0;
            a1_q        <= '0;
            d1_oe       <= 1'b0;
            d1_q        <= '0;
`ifdef BUS1_TIMEOUT_EN
            wait_cnt    <= '0;
            rsp_error_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        cmd_q       <= bus.req_cmd;
                        offset_q    <= bus.req_addr[CACHE_OFFSET_SIZE-1:0];
                        wdata_hi_q  <= bus.req_wdata[RDATA_W-1:DATA1_BUS_SIZE];
                        req_ready_q <= 1'b0;
                        c1_q        <= bus.req_cmd;
                        a1_oe       <= 1'b1;
                        a1_q        <= ADDR1_BUS_SIZE'(bus.req_addr[ADDR_W-1:CACHE_OFFSET_SIZE]);
                        d1_oe       <= is_write(bus.req_cmd);
                        d1_q        <= bus.req_wdata[DATA1_BUS_SIZE-1:0];
`ifdef BUS1_TIMEOUT_EN
                        rsp_error_q <= 1'b0;
`endif
                        state       <= S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    a1_q <= ADDR1_BUS_SIZE'(offset_q);
                    if (cmd_q == CMD_WRITE32) d1_q <= wdata_hi_q;
                    state <= S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    c1_oe <= 1'b0;
                    a1_oe <= 1'b0;
                    d1_oe <= 1'b0;
                    state <= S_TURN;
                end
                S_TURN: begin
`ifdef BUS1_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Anything other than RESPONSE (including Z/X/NOP) means "not yet".
                    if (C1 == CMD_RESPONSE) begin
                        if (is_read(cmd_q))
                            rsp_rdata_q <= (cmd_q == CMD_READ8) ? RDATA_W'(D1[7:0]) : RDATA_W'(D1);
                        if (cmd_q == CMD_READ32) begin
                            state <= S_RECV2;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            c1_oe       <= 1'b1;
                            c1_q        <= CMD_NOP;
                            state       <= S_DONE;
                        end
                    end
`ifdef BUS1_TIMEOUT_EN
                    else if (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_error_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        c1_oe       <= 1'b1;
                        c1_q        <= CMD_NOP;
                        state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + TMO_W'(1);
                    end
`endif
                end
                S_RECV2: begin
                    rsp_rdata_q[RDATA_W-1:DATA1_BUS_SIZE] <= D1;
                    rsp_valid_q <= 1'b1;
                    c1_oe       <= 1'b1;
                    c1_q        <= CMD_NOP;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    req_ready_q <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign C1 = c1_oe ? c1_q : {CTR1_BUS_SIZE{1'bz}};
    assign A1 = a1_oe ? a1_q : {ADDR1_BUS_SIZE{1'bz}};
    assign D1 = d1_oe ? d1_q : {DATA1_BUS_SIZE{1'bz}};

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef BUS1_TIMEOUT_EN
    assign bus.rsp_error = rsp_error_q;
`else
    assign bus.rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus1_master.sv
// Bench for cpu_bus1_master: vector table plus cache-side responder and response scoreboard.
// Released A1/D1 read as all ones through pull-ups; released C1 reads as NOP.
module tb_cpu_bus1_master;
    localparam int unsigned TMO = 8;

    logic CLK;
    logic RESET;

    tri1 [14:0] A1;
    tri1 [15:0] D1;
    tri0 [2:0]  C1;

    logic        c_oe, d_oe;
    logic [2:0]  c_val;
    logic [15:0] d_val;
    assign C1 = c_oe ? c_val : 3'bz;
    assign D1 = d_oe ? d_val : 16'bz;

    cpu_bus1_master_if #(.CMD_W(3), .ADDR_W(19), .DATA_W(16)) bus_if ();

    cpu_bus1_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if),
        .A1    (A1),
        .D1    (D1),
        .C1    (C1)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [18:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [15:0] rd_lo;
        logic [15:0] rd_hi;
        bit          hold;
        logic [14:0] a_hi;
        logic [14:0] a_lo;
        logic [15:0] d_ph1;
        logic [15:0] d_ph2;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    initial begin CLK = 1'b0; forever #5 CLK = ~CLK; end
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: every rsp_valid pulse must match the oldest accepted request.
    always @(negedge CLK) begin
        if (bus_if.rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", bus_if.rsp_rdata, mon_e.rdata);
                check("rsp_error", 32'(bus_if.rsp_error), 32'(mon_e.err));
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!bus_if.req_ready && k < 20) begin @(negedge CLK); k++; end
        check("ready_before_req", 32'(bus_if.req_ready), 32'd1);
    endtask

    task automatic wait_rsp(input int t0, input int exp_lat);
        int k = 0;
        do begin @(negedge CLK); k++; end while (!bus_if.rsp_valid && k < 40);
        check("rsp_arrived", 32'(bus_if.rsp_valid), 32'd1);
        check("latency", 32'(cyc - t0), 32'(exp_lat));
        @(negedge CLK);
        check("idle_ready", 32'(bus_if.req_ready), 32'd1);
        check("idle_c1", 32'(C1), 32'd0);
        check("idle_a1", 32'(A1), 32'h7FFF);
        check("idle_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    endtask

    task automatic run_txn(input vec_t v);
        int t0;
        bit r32;
        r32 = (v.cmd == 3'd3);
        wait_ready();
        bus_if.req_valid = 1'b1;
        bus_if.req_cmd   = v.cmd;
        bus_if.req_addr  = v.addr;
        bus_if.req_wdata = v.wdata;
        sb.push_back('{v.rdata, 1'b0});
        t0 = cyc;
        @(negedge CLK);
        check("hi_c1", 32'(C1), 32'(v.cmd));
        check("hi_a1", 32'(A1), 32'(v.a_hi));
        check("hi_d1", 32'(D1), 32'(v.d_ph1));
        check("hi_ready", 32'(bus_if.req_ready), 32'd0);
        // Scramble the request inputs to confirm they were latched at acceptance.
        bus_if.req_valid = v.hold;
        bus_if.req_cmd   = 3'd5;
        bus_if.req_addr  = '1;
        bus_if.req_wdata = '1;
        @(negedge CLK);
        check("lo_c1", 32'(C1), 32'(v.cmd));
        check("lo_a1", 32'(A1), 32'(v.a_lo));
        check("lo_d1", 32'(D1), 32'(v.d_ph2));
        @(negedge CLK);
        check("turn_c1", 32'(C1), 32'd0);
        check("turn_a1", 32'(A1), 32'h7FFF);
        check("turn_d1", 32'(D1), 32'hFFFF);
        @(negedge CLK);
        repeat (v.delay - 1) @(negedge CLK);
        c_val = 3'd7; c_oe = 1'b1;
        d_val = v.rd_lo; d_oe = 1'b1;
        bus_if.req_valid = 1'b0;
        @(posedge CLK); #1;
        c_oe = 1'b0;
        if (r32) begin
            @(negedge CLK);
            d_val = v.rd_hi;
            @(posedge CLK); #1;
        end
        d_oe = 1'b0;
        wait_rsp(t0, 4 + v.delay + (r32 ? 1 : 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        vecs[0] = '{3'd4, 19'h00223, 32'h0,        3, 16'h0,    16'h0,    1'b0, 15'h0022, 15'h3, 16'hFFFF, 16'hFFFF, 32'h0};
        vecs[1] = '{3'd7, 19'h4F2A7, 32'hDEADBEEF, 1, 16'h0,    16'h0,    1'b0, 15'h4F2A, 15'h7, 16'hBEEF, 16'hDEAD, 32'h0};
        vecs[2] = '{3'd3, 19'h7FFF0, 32'h0,        2, 16'h1234, 16'hABCD, 1'b0, 15'h7FFF, 15'h0, 16'hFFFF, 16'hFFFF, 32'hABCD1234};
        vecs[3] = '{3'd1, 19'h0001F, 32'h0,        1, 16'hFF5A, 16'h0,    1'b0, 15'h0001, 15'hF, 16'hFFFF, 16'hFFFF, 32'h0000005A};
        vecs[4] = '{3'd5, 19'h12345, 32'h123400C3, 2, 16'h0,    16'h0,    1'b0, 15'h1234, 15'h5, 16'h00C3, 16'h00C3, 32'h0000005A};
        vecs[5] = '{3'd2, 19'h00000, 32'h0,        4, 16'h8001, 16'h0,    1'b0, 15'h0000, 15'h0, 16'hFFFF, 16'hFFFF, 32'h00008001};
        vecs[6] = '{3'd6, 19'h2AAAA, 32'hFFFF5555, 1, 16'h0,    16'h0,    1'b0, 15'h2AAA, 15'hA, 16'h5555, 16'h5555, 32'h00008001};
        vecs[7] = '{3'd3, 19'h55555, 32'h0,        3, 16'h0F0F, 16'hF0F0, 1'b1, 15'h5555, 15'h5, 16'hFFFF, 16'hFFFF, 32'hF0F00F0F};

        RESET = 1'b1;
        c_oe = 1'b0; d_oe = 1'b0; c_val = '0; d_val = '0;
        bus_if.req_valid = 1'b0; bus_if.req_cmd = '0; bus_if.req_addr = '0; bus_if.req_wdata = '0;
        #12;
        check("rst_ready", 32'(bus_if.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("rst_rdata", bus_if.rsp_rdata, 32'd0);
        check("rst_error", 32'(bus_if.rsp_error), 32'd0);
        check("rst_c1", 32'(C1), 32'd0);
        check("rst_a1", 32'(A1), 32'h7FFF);
        check("rst_d1", 32'(D1), 32'hFFFF);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Reset asserted while waiting for the cache: abort with no response.
        wait_ready();
        bus_if.req_valid = 1'b1; bus_if.req_cmd = 3'd2; bus_if.req_addr = 19'h00100; bus_if.req_wdata = '0;
        @(negedge CLK);
        bus_if.req_valid = 1'b0;
        repeat (4) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check("midrst_c1", 32'(C1), 32'd0);
        check("midrst_a1", 32'(A1), 32'h7FFF);
        check("midrst_d1", 32'(D1), 32'hFFFF);
        check("midrst_ready", 32'(bus_if.req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("midrst_rdata", bus_if.rsp_rdata, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        run_txn(vecs[3]);

`ifdef BUS1_TIMEOUT_EN
        // No cache answer: timeout completes with error and rdata kept.
        wait_ready();
        bus_if.req_valid = 1'b1; bus_if.req_cmd = 3'd2; bus_if.req_addr = 19'h00100; bus_if.req_wdata = '0;
        sb.push_back('{32'h0000005A, 1'b1});
        t0 = cyc;
        @(negedge CLK);
        bus_if.req_valid = 1'b0;
        wait_rsp(t0, 4 + TMO);
        check("tmo_error_held", 32'(bus_if.rsp_error), 32'd1);
        run_txn(vecs[5]);
`endif
        t0 = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
